// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
//
// Shared definitions for the pipeline skid register:
//   - state_e     : occupancy state of the two-entry skid buffer
//   - DEF_*       : default widths for payload, control, tag and stall counter
//   - occ_of()    : maps a state to its entry count (0..2)
// -----------------------------------------------------------------------------
package pipe_pkg;

    // The encoding equals the number of held entries, so the occupancy output
    // is a direct view of the state register.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_CTRL_W = 2;
    localparam int DEF_TAG_W  = 5;
    localparam int DEF_CNT_W  = 16;

    function automatic logic [1:0] occ_of(input state_e st);
        logic [1:0] occ;
        occ = 2'd0;
        case (st)
            EMPTY:   occ = 2'd0;
            ONE:     occ = 2'd1;
            FULL:    occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// pipe_skid_reg
//
// Two-entry pipeline register (main + skid slot) between two pipeline stages.
// The head entry always lives in the main slot and drives the outputs; the
// skid slot catches the one entry that can arrive while the downstream stalls,
// which lets in_ready be a flop with no combinational path from out_ready.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both 1. The sender holds valid and payload until that edge; valid never
// depends on ready in the same cycle. in_ready is registered; out_valid and
// the head payload come straight from flops (out_ctrl is masked by out_valid).
//
// Ports
//   clk        in   clock, all state updates on the rising edge
//   reset      in   synchronous, active-high; beats flush and all transfers
//   in_valid   in   upstream entry present
//   in_ready   out  stage can accept (0 only when both slots are full)
//   in_data    in   upstream payload        [DATA_W]
//   in_ctrl    in   upstream control bits   [CTRL_W]
//   in_tag     in   upstream destination register number [TAG_W]
//   flush      in   drop both held entries and any input this cycle
//   out_valid  out  downstream entry present
//   out_ready  in   downstream accepts
//   out_data   out  head payload
//   out_ctrl   out  head control bits, forced to zero when out_valid=0
//   out_tag    out  head destination register number
//   occupancy  out  number of held entries (0..2); mirrors the FSM state
//   stall_cnt  out  saturating count of cycles with out_valid=1, out_ready=0
// -----------------------------------------------------------------------------
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CTRL_W = DEF_CTRL_W,
    parameter int TAG_W  = DEF_TAG_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [TAG_W-1:0]  in_tag,

    input  logic              flush,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [TAG_W-1:0]  out_tag,

    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Slot layout: {ctrl, tag, data}
    localparam int ENT_W     = CTRL_W + TAG_W + DATA_W;
    localparam int TAG_LSB   = DATA_W;
    localparam int CTRL_LSB  = DATA_W + TAG_W;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e             state_q, state_d;
    logic [ENT_W-1:0]   main_q,  main_d;
    logic [ENT_W-1:0]   skid_q,  skid_d;
    logic               in_ready_q;
    logic [CNT_W-1:0]   stall_q, stall_d;

    logic               xfer_in;
    logic               xfer_out;
    logic [ENT_W-1:0]   in_ent;

    assign in_ent   = {in_ctrl, in_tag, in_data};

    // in_ready_q is 0 exactly when state_q is FULL, so no extra gating is
    // needed to keep the FULL state from accepting.
    assign xfer_in  = in_valid & in_ready_q;
    assign xfer_out = out_valid & out_ready;

    // -------------------------------------------------------------------------
    // Next-state and slot data
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        if (flush) begin
            // Clearing the slots keeps out_data/out_tag at zero while empty.
            state_d = EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (xfer_in) begin
                        state_d = ONE;
                        main_d  = in_ent;
                    end
                end
                ONE: begin
                    if (xfer_in && xfer_out) begin
                        main_d  = in_ent;
                    end else if (xfer_in) begin
                        state_d = FULL;
                        skid_d  = in_ent;
                    end else if (xfer_out) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    // The skid entry is younger, so it becomes the new head.
                    if (xfer_out) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = '0;
                    skid_d  = '0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Stall counter: saturates, and survives flush (only reset clears it)
    // -------------------------------------------------------------------------
    always_comb begin
        stall_d = stall_q;
        if (out_valid && !out_ready && (stall_q != CNT_MAX)) begin
            stall_d = stall_q + CNT_ONE;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            // Registered from the next state: ready drops the cycle FULL is
            // entered and returns the cycle FULL is left.
            in_ready_q <= (state_d != FULL);
            stall_q    <= stall_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q[DATA_W-1:0];
    assign out_tag   = main_q[TAG_LSB +: TAG_W];
    assign out_ctrl  = out_valid ? main_q[CTRL_LSB +: CTRL_W] : '0;
    assign occupancy = occ_of(state_q);
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
module tb_pipe_skid_reg;

    localparam int DW   = 32;
    localparam int CW   = 2;
    localparam int TW   = 5;
    localparam int CNTW = 4;
    localparam int CMAX = (1 << CNTW) - 1;

    // ---------------------------------------------------------------- clock/reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_data;
    logic [CW-1:0]   in_ctrl;
    logic [TW-1:0]   in_tag;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic [CW-1:0]   out_ctrl;
    logic [TW-1:0]   out_tag;
    logic [1:0]      occupancy;
    logic [CNTW-1:0] stall_cnt;

    pipe_skid_reg #(.DATA_W(DW), .CTRL_W(CW), .TAG_W(TW), .CNT_W(CNTW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .in_tag    (in_tag),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .out_tag   (out_tag),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    // ---------------------------------------------------------------- scoreboard
    typedef struct packed {
        logic [CW-1:0] c;
        logic [TW-1:0] t;
        logic [DW-1:0] d;
    } ent_t;

    ent_t exp_q[$];     // entries held by the stage, head first
    int   m_cnt;        // expected stall count
    bit   m_zero;       // no entry accepted since last reset/flush
    int   n_checks;
    int   n_fail;

    // ---------------------------------------------------------------- drivers
    task automatic drive(input bit v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                         input logic [TW-1:0] t, input bit ordy, input bit fl);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        in_tag    = t;
        out_ready = ordy;
        flush     = fl;
    endtask

    // One clock: the model consumes the inputs seen at the edge, then the bench
    // waits for the falling edge where outputs are sampled.
    task automatic step();
        bit   do_in, do_out;
        ent_t e;
        @(posedge clk);
        if (reset) begin
            exp_q.delete();
            m_cnt  = 0;
            m_zero = 1'b1;
        end else begin
            if (exp_q.size() > 0 && !out_ready && m_cnt < CMAX) m_cnt++;
            if (flush) begin
                exp_q.delete();
                m_zero = 1'b1;
            end else begin
                do_out = (exp_q.size() > 0) && out_ready;
                do_in  = in_valid && (exp_q.size() < 2);
                if (do_out) void'(exp_q.pop_front());
                if (do_in) begin
                    e.c = in_ctrl; e.t = in_tag; e.d = in_data;
                    exp_q.push_back(e);
                    m_zero = 1'b0;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        reset = 1'b1;
        drive(1'b1, 32'h1234_5678, 2'b11, 5'd3, 1'b0, 1'b1);
        step();
        step();
        reset = 1'b0;
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
        n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", out_data); end
        n_checks++; if (out_ctrl !== '0) begin n_fail++; $display("FAIL reset_ctrl got=%b exp=0", out_ctrl); end
        n_checks++; if (out_tag !== '0) begin n_fail++; $display("FAIL reset_tag got=%0d exp=0", out_tag); end
        n_checks++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
        n_checks++; if (stall_cnt !== '0) begin n_fail++; $display("FAIL reset_stall got=%0d exp=0", stall_cnt); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    endtask

    task automatic test_single();
        drive(1'b1, 32'hDEAD_BEEF, 2'b11, 5'd7, 1'b1, 1'b0);
        step();
        drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got=%0b exp=1", out_valid); end
        n_checks++; if (out_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_data got=%h exp=deadbeef", out_data); end
        n_checks++; if (out_ctrl !== 2'b11) begin n_fail++; $display("FAIL single_ctrl got=%b exp=11", out_ctrl); end
        n_checks++; if (out_tag !== 5'd7) begin n_fail++; $display("FAIL single_tag got=%0d exp=7", out_tag); end
        n_checks++; if (occupancy !== 2'd1) begin n_fail++; $display("FAIL single_occ got=%0d exp=1", occupancy); end
        step();
        n_checks++; if (out_valid !== 1'b0 || out_ctrl !== '0) begin
            n_fail++; $display("FAIL single_drain valid=%0b ctrl=%b exp valid=0 ctrl=0", out_valid, out_ctrl); end
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 8; i++) begin
            n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready[%0d] got=%0b exp=1", i, in_ready); end
            drive(1'b1, DW'(i), CW'(i), TW'(i + 8), 1'b1, 1'b0);
            step();
            n_checks++; if (out_valid !== 1'b1 || out_data !== DW'(i) || out_tag !== TW'(i + 8)) begin
                n_fail++; $display("FAIL b2b_out[%0d] valid=%0b data=%h tag=%0d exp valid=1 data=%h tag=%0d",
                                   i, out_valid, out_data, out_tag, DW'(i), i + 8); end
        end
        drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
        step();
        n_checks++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL b2b_end_occ got=%0d exp=0", occupancy); end
    endtask

    task automatic test_full_drain();
        drive(1'b1, 32'hA, 2'b01, 5'd10, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'hB, 2'b10, 5'd11, 1'b0, 1'b0);
        step();
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
        n_checks++; if (occupancy !== 2'd2) begin n_fail++; $display("FAIL full_occ got=%0d exp=2", occupancy); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready got=%0b exp=0", in_ready); end
        n_checks++; if (out_data !== 32'hA) begin n_fail++; $display("FAIL full_head got=%h exp=a", out_data); end
        // Offer a third entry while full; it must not be taken.
        drive(1'b1, 32'hE, 2'b11, 5'd12, 1'b0, 1'b0);
        step();
        n_checks++; if (out_data !== 32'hA || out_ctrl !== 2'b01 || out_tag !== 5'd10) begin
            n_fail++; $display("FAIL full_hold data=%h ctrl=%b tag=%0d exp data=a ctrl=01 tag=10", out_data, out_ctrl, out_tag); end
        drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
        step();
        n_checks++; if (out_data !== 32'hB || occupancy !== 2'd1) begin
            n_fail++; $display("FAIL drain_second data=%h occ=%0d exp data=b occ=1", out_data, occupancy); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL drain_in_ready got=%0b exp=1", in_ready); end
        step();
        n_checks++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL drain_empty_occ got=%0d exp=0", occupancy); end
    endtask

    task automatic test_flush();
        drive(1'b1, 32'hA, 2'b01, 5'd1, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'hB, 2'b10, 5'd2, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'hC, 2'b11, 5'd3, 1'b0, 1'b1);
        step();
        drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
        n_checks++; if (out_valid !== 1'b0 || out_ctrl !== '0 || occupancy !== 2'd0) begin
            n_fail++; $display("FAIL flush_empty valid=%0b ctrl=%b occ=%0d exp 0/0/0", out_valid, out_ctrl, occupancy); end
        n_checks++; if (out_data !== '0 || out_tag !== '0) begin
            n_fail++; $display("FAIL flush_zero data=%h tag=%0d exp 0/0", out_data, out_tag); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready got=%0b exp=1", in_ready); end
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (out_valid !== 1'b0 || out_data === 32'hC) begin
                n_fail++; $display("FAIL flush_no_c[%0d] valid=%0b data=%h exp valid=0", i, out_valid, out_data); end
        end
        // Flush while empty drops the input offered in that cycle.
        drive(1'b1, 32'hD, 2'b11, 5'd4, 1'b1, 1'b1);
        step();
        drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
        n_checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            n_fail++; $display("FAIL flush_idle valid=%0b occ=%0d exp 0/0", out_valid, occupancy); end
    endtask

    task automatic test_stall_sat();
        do_reset();
        drive(1'b1, 32'h55, 2'b10, 5'd9, 1'b0, 1'b0);
        step();
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 5) begin
                n_checks++; if (stall_cnt !== CNTW'(5)) begin n_fail++; $display("FAIL stall_count5 got=%0d exp=5", stall_cnt); end
            end
        end
        n_checks++; if (stall_cnt !== CNTW'(CMAX)) begin n_fail++; $display("FAIL stall_sat got=%0d exp=%0d", stall_cnt, CMAX); end
        n_checks++; if (out_data !== 32'h55) begin n_fail++; $display("FAIL stall_hold got=%h exp=55", out_data); end
        drive(1'b0, '0, '0, '0, 1'b0, 1'b1);
        step();
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
        n_checks++; if (stall_cnt !== CNTW'(CMAX) || occupancy !== 2'd0) begin
            n_fail++; $display("FAIL stall_after_flush cnt=%0d occ=%0d exp cnt=%0d occ=0", stall_cnt, occupancy, CMAX); end
    endtask

    task automatic test_reset_priority();
        drive(1'b1, 32'hA, 2'b11, 5'd5, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'hB, 2'b11, 5'd6, 1'b0, 1'b0);
        step();
        reset = 1'b1;
        drive(1'b1, 32'hC, 2'b11, 5'd7, 1'b1, 1'b1);
        step();
        reset = 1'b0;
        drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
        n_checks++; if (out_valid !== 1'b0 || out_data !== '0 || out_ctrl !== '0 || out_tag !== '0) begin
            n_fail++; $display("FAIL rstprio_out valid=%0b data=%h ctrl=%b tag=%0d exp all 0", out_valid, out_data, out_ctrl, out_tag); end
        n_checks++; if (occupancy !== 2'd0 || stall_cnt !== '0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL rstprio_state occ=%0d stall=%0d rdy=%0b exp 0/0/1", occupancy, stall_cnt, in_ready); end
    endtask

    task automatic test_random();
        ent_t h;
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            drive($urandom_range(0, 3) != 0, DW'($urandom), CW'($urandom), TW'($urandom),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 29) == 0);
            step();
            n_checks++; if (occupancy !== 2'(exp_q.size()) || out_valid !== (exp_q.size() > 0)) begin
                n_fail++; $display("FAIL rnd_occ[%0d] occ=%0d valid=%0b exp occ=%0d", i, occupancy, out_valid, exp_q.size()); end
            n_checks++; if (in_ready !== (exp_q.size() < 2)) begin
                n_fail++; $display("FAIL rnd_in_ready[%0d] got=%0b exp=%0b", i, in_ready, exp_q.size() < 2); end
            n_checks++; if (stall_cnt !== CNTW'(m_cnt)) begin
                n_fail++; $display("FAIL rnd_stall[%0d] got=%0d exp=%0d", i, stall_cnt, m_cnt); end
            if (exp_q.size() > 0) begin
                h = exp_q[0];
                n_checks++; if (out_data !== h.d || out_ctrl !== h.c || out_tag !== h.t) begin
                    n_fail++; $display("FAIL rnd_head[%0d] data=%h ctrl=%b tag=%0d exp data=%h ctrl=%b tag=%0d",
                                       i, out_data, out_ctrl, out_tag, h.d, h.c, h.t); end
            end else begin
                n_checks++; if (out_ctrl !== '0) begin n_fail++; $display("FAIL rnd_idle_ctrl[%0d] got=%b exp=0", i, out_ctrl); end
                if (m_zero) begin
                    n_checks++; if (out_data !== '0 || out_tag !== '0) begin
                        n_fail++; $display("FAIL rnd_idle_zero[%0d] data=%h tag=%0d exp 0/0", i, out_data, out_tag); end
                end
            end
        end
        reset = 1'b0;
    endtask

    // ---------------------------------------------------------------- sequence
    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_cnt    = 0;
        m_zero   = 1'b1;
        reset    = 1'b1;
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
        test_reset();
        test_single();
        test_back_to_back();
        test_full_drain();
        test_flush();
        test_stall_sat();
        test_reset_priority();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
